// File: rtl/serial_lane_arbiter_if.sv
// Requester-side bus and serializer-side byte stream of the serial lane arbiter.
// The arbiter connects through the slave modport; requesters drive the master modport.
interface serial_lane_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] data_in;
    logic [NUM_REQ-1:0]   valid_in;
    logic [NUM_REQ-1:0]   last_in;
    logic [NUM_REQ-1:0]   ready_out;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           data_out;
    logic                 valid_out;
    logic                 busy;

    modport master (
        output req, data_in, valid_in, last_in,
        input  ready_out, grant, data_out, valid_out, busy
    );

    modport slave (
        input  req, data_in, valid_in, last_in,
        output ready_out, grant, data_out, valid_out, busy
    );
endinterface

// File: rtl/serial_lane_arbiter.sv
// Shares one serializer lane among NUM_REQ byte streams: header, payload, idle gap.
// Define FIXED_PRIO_EN for strict lowest-index-wins arbitration instead of round-robin.
module serial_lane_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16,
    parameter int GAP_CYCLES = 2
) (
    input logic                  clk_4f,
    input logic                  reset,
    serial_lane_arbiter_if.slave lane
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} state_t;

    state_t             state_q, state_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic [7:0]         data_q, data_n;
    logic               valid_q, valid_n;
    logic               busy_q, busy_n;
    logic [CNT_W-1:0]   count_q, count_n;
    logic [3:0]         gap_q, gap_n;
    logic [IDX_W-1:0]   owner_q, owner_n;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [7:0]         sel_data;
    logic               sel_valid;
    logic               sel_last;

`ifdef FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the one left standing.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (lane.req[k]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr_q, ptr_n;
    int               cand;

    // Scan upward from the requester after the last winner, wrapping at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && lane.req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end
`endif

    // Payload path of the current owner; other requesters' strobes never reach the FSM.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                sel_data  = lane.data_in[8*k +: 8];
                sel_valid = lane.valid_in[k];
                sel_last  = lane.last_in[k];
            end
        end
    end

    // NOTE: every next-state signal is defaulted to its held value first, so no path infers a latch.
    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        data_n  = data_q;
        valid_n = 1'b0;
        busy_n  = busy_q;
        count_n = count_q;
        gap_n   = gap_q;
        owner_n = owner_q;
`ifndef FIXED_PRIO_EN
        ptr_n   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                data_n = 8'h00;
                if (win_found) begin
                    grant_n = NUM_REQ'(1) << win_idx;
                    owner_n = win_idx;
`ifndef FIXED_PRIO_EN
                    ptr_n   = win_idx;
`endif
                    // High nibble 0xA keeps a header distinct from the 0xBC fill symbol.
                    data_n  = {4'hA, 1'b0, 3'(win_idx)};
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    state_n = HEADER;
                end
            end
            HEADER: begin
                count_n = '0;
                state_n = PAYLOAD;
            end
            PAYLOAD: begin
                if (sel_valid) begin
                    data_n  = sel_data;
                    valid_n = 1'b1;
                    count_n = count_q + 1'b1;
                    if (sel_last || count_n == CNT_W'(MAX_BURST)) begin
                        grant_n = '0;
                        if (GAP_CYCLES == 0) begin
                            busy_n  = 1'b0;
                            state_n = IDLE;
                        end else begin
                            gap_n   = 4'(GAP_CYCLES);
                            state_n = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q <= 4'd1) begin
                    gap_n   = '0;
                    busy_n  = 1'b0;
                    data_n  = 8'h00;
                    state_n = IDLE;
                end else begin
                    gap_n = gap_q - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
            gap_q   <= '0;
            owner_q <= '0;
`ifndef FIXED_PRIO_EN
            ptr_q   <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            count_q <= count_n;
            gap_q   <= gap_n;
            owner_q <= owner_n;
`ifndef FIXED_PRIO_EN
            ptr_q   <= ptr_n;
`endif
        end
    end

    assign lane.grant     = grant_q;
    assign lane.data_out  = data_q;
    assign lane.valid_out = valid_q;
    assign lane.busy      = busy_q;
    assign lane.ready_out = (state_q == PAYLOAD) ? grant_q : '0;
endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Bench for serial_lane_arbiter: requester models feed byte queues, a scoreboard holds the expected lane bytes.
// Expected header order follows FIXED_PRIO_EN when the bench is built with it.
module tb_serial_lane_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int MAX_BURST  = 16;
    localparam int GAP_CYCLES = 2;

    logic clk_4f = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_4f = ~clk_4f;

    serial_lane_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    serial_lane_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk_4f(clk_4f),
        .reset (reset),
        .lane  (bus)
    );

    typedef struct {
        int         src;
        int         len;
        bit         last;
        logic [7:0] first;
        logic [7:0] exp_hdr;
        int         exp_acc;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         last_v_cyc = 0;
    int         fall_cyc   = 0;
    bit         prev_busy  = 1'b0;
    logic [8:0] src_q [NUM_REQ][$];   // {last, byte} per pending payload byte
    bit         bubble [NUM_REQ];
    int         acc_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] req_mask = '0;
    logic [7:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pending();
        int p = sb.size() + int'(bus.busy);
        for (int i = 0; i < NUM_REQ; i++) p += src_q[i].size();
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            bit         has;
            logic [8:0] head;
            has  = src_q[i].size() > 0;
            head = has ? src_q[i][0] : 9'h000;
            bus.req[i]           = req_mask[i] & has;
            bus.valid_in[i]      = has & ~bubble[i];
            bus.last_in[i]       = has & ~bubble[i] & head[8];
            bus.data_in[8*i +: 8] = head[7:0];
        end
    endtask

    task automatic tick();
        logic [NUM_REQ-1:0] acc;
        logic [8:0]         dropped;
        drive();
        acc = bus.ready_out & bus.valid_in;
        @(posedge clk_4f);
        #1;
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                dropped = src_q[i].pop_front();
                acc_cnt[i]++;
            end
        end
        if (bus.valid_out) begin
            last_v_cyc = cyc;
            if (sb.size() == 0) check("sb_unexpected_byte", 32'(sb.size()), 32'd1);
            else                check("sb_byte", 32'(bus.data_out), 32'(sb.pop_front()));
        end
        if (prev_busy && !bus.busy) fall_cyc = cyc;
        prev_busy = bus.busy;
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (pending() != 0 && n < budget);
        check("drain_pending", 32'(pending()), 32'd0);
    endtask

    task automatic wait_acc(input int idx, input int target, input int budget);
        int n = 0;
        while (acc_cnt[idx] < target && n < budget) begin
            tick();
            n++;
        end
        check("acc_reached", 32'(acc_cnt[idx]), 32'(target));
    endtask

    task automatic clear_acc();
        for (int i = 0; i < NUM_REQ; i++) acc_cnt[i] = 0;
    endtask

    task automatic apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            bubble[i] = 1'b0;
        end
        clear_acc();
        sb.delete();
        req_mask = '0;
        drive();
        reset = 1'b0;
        #1;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready_out", 32'(bus.ready_out), 32'd0);
        repeat (2) @(posedge clk_4f);
        #1;
        reset     = 1'b1;
        prev_busy = 1'b0;
    endtask

    task automatic load(input int src, input int len, input bit last, input logic [7:0] first);
        for (int k = 0; k < len; k++) begin
            logic [7:0] b;
            b = first + 8'(k * 17);
            src_q[src].push_back({last && (k == len - 1), b});
        end
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{src: 0, len: 2,  last: 1'b1, first: 8'hF0, exp_hdr: 8'hA0, exp_acc: 2};
        vecs[1] = '{src: 1, len: 1,  last: 1'b1, first: 8'h5A, exp_hdr: 8'hA1, exp_acc: 1};
        vecs[2] = '{src: 2, len: 16, last: 1'b1, first: 8'h01, exp_hdr: 8'hA2, exp_acc: 16};
        vecs[3] = '{src: 3, len: 5,  last: 1'b1, first: 8'h30, exp_hdr: 8'hA3, exp_acc: 5};

        drive();
        #2;
        apply_reset();

        // Single three-byte burst with exact cycle timing.
        src_q[0].push_back(9'h011);
        src_q[0].push_back(9'h022);
        src_q[0].push_back(9'h133);
        req_mask = 4'b0001;
        sb.push_back(8'hA0); sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
        tick();
        check("a_hdr_valid", 32'(bus.valid_out), 32'd1);
        check("a_hdr_grant", 32'(bus.grant), 32'b0001);
        check("a_hdr_busy", 32'(bus.busy), 32'd1);
        tick();
        check("a_post_hdr_valid", 32'(bus.valid_out), 32'd0);
        check("a_ready", 32'(bus.ready_out), 32'b0001);
        repeat (3) begin
            tick();
            check("a_payload_valid", 32'(bus.valid_out), 32'd1);
        end
        check("a_end_grant", 32'(bus.grant), 32'd0);
        check("a_end_ready", 32'(bus.ready_out), 32'd0);
        tick();
        check("a_gap1_valid", 32'(bus.valid_out), 32'd0);
        check("a_gap1_busy", 32'(bus.busy), 32'd1);
        tick();
        check("a_gap2_valid", 32'(bus.valid_out), 32'd0);
        check("a_gap2_busy", 32'(bus.busy), 32'd0);
        check("a_acc", 32'(acc_cnt[0]), 32'd3);

        // Table of single-requester bursts, including last and limit on the same byte.
        for (int v = 0; v < 4; v++) begin
            clear_acc();
            load(vecs[v].src, vecs[v].len, vecs[v].last, vecs[v].first);
            sb.push_back(vecs[v].exp_hdr);
            for (int k = 0; k < vecs[v].exp_acc; k++) sb.push_back(vecs[v].first + 8'(k * 17));
            req_mask = NUM_REQ'(1) << vecs[v].src;
            run_until_idle(100);
            check("vec_acc", 32'(acc_cnt[vecs[v].src]), 32'(vecs[v].exp_acc));
            check("vec_gap_len", 32'(fall_cyc - last_v_cyc), 32'(GAP_CYCLES));
        end

        // All requesters held: arbitration order of one-byte bursts.
        clear_acc();
        src_q[0].push_back(9'h1C0);
        src_q[0].push_back(9'h1C4);
        src_q[1].push_back(9'h1C1);
        src_q[2].push_back(9'h1C2);
        src_q[3].push_back(9'h1C3);
        req_mask = 4'b1111;
`ifdef FIXED_PRIO_EN
        sb = '{8'hA0, 8'hC0, 8'hA0, 8'hC4, 8'hA1, 8'hC1, 8'hA2, 8'hC2, 8'hA3, 8'hC3};
`else
        sb = '{8'hA0, 8'hC0, 8'hA1, 8'hC1, 8'hA2, 8'hC2, 8'hA3, 8'hC3, 8'hA0, 8'hC4};
`endif
        run_until_idle(200);

        // Twenty bytes without last: forced release at sixteen, then re-grant for the rest.
        clear_acc();
        for (int k = 0; k < 20; k++) src_q[2].push_back({1'b0, 8'(8'h40 + k)});
        req_mask = 4'b0100;
        sb.push_back(8'hA2);
        for (int k = 0; k < 16; k++) sb.push_back(8'(8'h40 + k));
        sb.push_back(8'hA2);
        for (int k = 16; k < 20; k++) sb.push_back(8'(8'h40 + k));
        wait_acc(2, 16, 100);
        check("c_ready_fell", 32'(bus.ready_out[2]), 32'd0);
        check("c_grant_released", 32'(bus.grant), 32'd0);
        wait_acc(2, 20, 100);
        repeat (3) tick();
        check("c_sb_drained", 32'(sb.size()), 32'd0);
        check("c_burst_open_grant", 32'(bus.grant), 32'b0100);
        check("c_burst_open_busy", 32'(bus.busy), 32'd1);
        apply_reset();

        // Three-cycle valid_in bubble mid-burst.
        for (int k = 0; k < 6; k++) src_q[1].push_back({k == 5, 8'(8'h61 + k)});
        req_mask = 4'b0010;
        sb.push_back(8'hA1);
        for (int k = 0; k < 6; k++) sb.push_back(8'(8'h61 + k));
        wait_acc(1, 2, 20);
        bubble[1] = 1'b1;
        repeat (3) begin
            tick();
            check("d_bubble_valid", 32'(bus.valid_out), 32'd0);
            check("d_bubble_grant", 32'(bus.grant), 32'b0010);
        end
        bubble[1] = 1'b0;
        run_until_idle(50);
        check("d_acc", 32'(acc_cnt[1]), 32'd6);

        // Reset during the second payload byte, then the pointer must restart at requester 0.
        clear_acc();
        src_q[1].push_back(9'h071);
        src_q[1].push_back(9'h072);
        src_q[1].push_back(9'h173);
        req_mask = 4'b0010;
        sb = '{8'hA1, 8'h71, 8'h72, 8'h73};
        wait_acc(1, 1, 20);
        apply_reset();
        src_q[1].push_back(9'h181);
        src_q[2].push_back(9'h182);
        req_mask = 4'b0110;
        sb = '{8'hA1, 8'h81, 8'hA2, 8'h82};
        tick();
        check("e_first_grant", 32'(bus.grant), 32'b0010);
        run_until_idle(60);

        check("sb_final_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/serial_lane_arbiter.md
Name: serial_lane_arbiter

Overview:
- Shares one paralelo_serial lane between NUM_REQ byte-stream requesters at the byte clock clk_4f.
- Arbitrates round-robin and frames each burst as a header byte (source ID), then payload, then an idle gap.
- Drives the serializer's data_in/valid_in. When valid_out=0, the serializer fills the line with COM (0xBC).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum payload bytes per grant; reaching it forces release (1..255).
- GAP_CYCLES, 2, idle clk_4f cycles inserted after every burst (0..15).

Ports:
- clk_4f  input  1  byte-rate clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester burst request; level, sampled only in IDLE.
- data_in  input  8*NUM_REQ  payload bytes; requester i on bits [8i+7:8i].
- valid_in  input  NUM_REQ  payload byte valid, per requester.
- last_in  input  NUM_REQ  marks the final payload byte of the burst; qualified by valid_in.
- ready_out  output  NUM_REQ  payload accept; combinational, (state==PAYLOAD) & grant.
- grant  output  NUM_REQ  registered one-hot of the current owner; all-zero when idle.
- data_out  output  8  byte to the serializer.
- valid_out  output  1  data_out valid; 0 means the serializer sends 0xBC.
- busy  output  1  high in HEADER, PAYLOAD and GAP.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, grant=0, data_out=8'h00, valid_out=0, busy=0.
  - Payload counter=0; rr pointer (last granted)=NUM_REQ-1, so requester 0 wins first.
- States: IDLE, HEADER, PAYLOAD, GAP.
- IDLE:
  - valid_out=0, data_out=8'h00.
  - If req!=0 at an edge, that edge performs the following:
    - Select the winner: the first set bit scanning upward from pointer+1, with wrap.
    - grant<=onehot(winner), pointer<=winner, data_out<={4'hA, 1'b0, winner[2:0]}, valid_out<=1, busy<=1, state<=HEADER.
  - Latency is one edge from sampled req to header on data_out.
- HEADER: lasts one cycle. Next edge: valid_out<=0, count<=0, state<=PAYLOAD.
- PAYLOAD:
  - At each edge with valid_in[g]=1 (g=granted index): data_out<=data_in[g], valid_out<=1, count<=count+1.
  - With valid_in[g]=0: valid_out<=0 and data_out holds. The burst stays open indefinitely; no timeout.
  - Burst ends on an accepted byte with last_in[g]=1, or on the accepted byte that makes count==MAX_BURST. Last and limit together count as one end.
  - On end: state<=GAP, grant<=0, and the gap counter loads GAP_CYCLES.
  - If GAP_CYCLES=0, go straight to IDLE with busy<=0.
  - On a forced end, the requester sees ready_out fall and must re-request to send the remainder.
- GAP:
  - valid_out=0, grant=0.
  - The gap counter decrements each edge; on reaching 0, state<=IDLE and busy<=0.
  - Requests are not sampled in GAP.
- Inputs outside the burst:
  - req changes outside IDLE are ignored; a deasserted req does not abort a burst.
  - valid_in/last_in of non-granted requesters are ignored.
- The header high nibble 4'hA guarantees the header never equals 0xBC.
- Widths: count is $clog2(MAX_BURST+1) bits; the gap counter is 4 bits.
- Reset mid-burst: outputs return immediately to reset values and the pointer returns to NUM_REQ-1. The partial burst is dropped with no trailing gap.

Optional Feature:
- FIXED_PRIO_EN defined: arbitration is strict fixed priority, lowest index wins, and the pointer is unused.
- FIXED_PRIO_EN undefined: round-robin as above.
- Framing, gap and timing are identical in both builds.

Test Plan:
- Reset, then req=4'b0001, and requester 0 sends 0x11,0x22,0x33 (last on 0x33) with valid held:
  - Output: header 0xA0, then 0x11,0x22,0x33 with valid_out=1 on consecutive cycles.
  - Then 2 cycles of valid_out=0, then IDLE.
- req=4'b1111 held continuously, each requester sending a 1-byte burst: headers appear in order 0xA0, 0xA1, 0xA2, 0xA3, 0xA0. With FIXED_PRIO_EN defined, every header is 0xA0.
- Requester 2 alone, never asserting last, 20 valid bytes: exactly 16 bytes are accepted and ready_out[2] falls after the 16th. After the gap, header 0xA2 is reissued and the remaining 4 bytes are sent.
- valid_in bubble (valid_in[g]=0 for 3 cycles mid-burst): valid_out=0 for those 3 cycles and grant is held. Bytes resume in order and no byte is duplicated or lost.
- reset pulsed low during the second payload byte: grant=0, valid_out=0, data_out=0x00 immediately. After release with req=4'b0010, the first header is 0xA1.
- Simultaneous last_in and MAX_BURST (burst of exactly 16 with last on the 16th): exactly one gap of 2 cycles and no extra header.
